apb_master_sched: RTL and testbench

APB master sequencer that shares one APB bus between NUM_REQ requesters, such as CPU and DMA ports. Uses round-robin arbitration. Drives the full SETUP/ACCESS protocol, decodes the address into a one-hot psel for 4 slaves, and waits on pready with a timeout. Returns read data and error status to the granted requester. Sits between the requester fabric and the slave interface that owns psel[3:0].

---
 rtl/apb_master_sched.sv | 160 ++++++++++++++++
 tb/tb_apb_master_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_sched.sv
// APB master sequencer: round-robin arbitration of NUM_REQ requesters onto one APB bus,
// with one-hot slave decode, SETUP/ACCESS sequencing and a pready timeout.
module apb_master_sched #(
    parameter int NUM_REQ = 2,
    parameter int SLV_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [32*NUM_REQ-1:0]  req_wdata,
    input  logic [4*NUM_REQ-1:0]   req_strb,
    input  logic [3*NUM_REQ-1:0]   req_prot,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [3:0]             psel,
    output logic                   penable,
    output logic [31:0]            paddr,
    output logic                   pwrite,
    output logic [2:0]             pprot,
    output logic [31:0]            pwdata,
    output logic [3:0]             pstrb,
    input  logic [31:0]            prdata,
    input  logic                   pready,
    input  logic                   pslverr,
    output logic [1:0]             dbg_state
);

    // Handshake: a requester holds req_valid with stable fields until the single-cycle
    // req_ready pulse; the result comes back later as a single-cycle rsp_valid pulse.

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            active;
    logic [1:0]      ptr;
    logic [1:0]      cur_idx;
    logic [1:0]      gnt_idx;
    logic            gnt_any;
    logic            gnt_ok;
    logic [CW-1:0]   cnt;
    logic            acc_done;
    logic            acc_tmo;
    int              scan_idx;
    int              gi;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_write;
    logic [3:0]      sel_strb;
    logic [2:0]      sel_prot;

    // Scan downward so the last hit, i.e. the first one at or after ptr, wins.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = 2'd0;
        scan_idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = 2'(scan_idx);
            end
        end
    end

    always_comb begin
        gi        = int'(gnt_idx);
        sel_addr  = req_addr[gi*32 +: 32];
        sel_wdata = req_wdata[gi*32 +: 32];
        sel_write = req_write[gi];
        sel_strb  = req_strb[gi*4 +: 4];
        sel_prot  = req_prot[gi*3 +: 3];
    end

    // active holds off grants until the first clock edge after reset release.
    assign gnt_ok    = (state == IDLE) && active && gnt_any;
    assign req_ready = gnt_ok ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign acc_done  = (state == ACCESS) && pready;
    assign acc_tmo   = (state == ACCESS) && !pready && (cnt == CW'(TIMEOUT - 1));
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_ok) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (acc_done || acc_tmo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            active    <= 1'b0;
            ptr       <= 2'd0;
            cur_idx   <= 2'd0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            psel      <= 4'd0;
            penable   <= 1'b0;
            paddr     <= 32'd0;
            pwrite    <= 1'b0;
            pprot     <= 3'd0;
            pwdata    <= 32'd0;
            pstrb     <= 4'd0;
        end else begin
            active    <= 1'b1;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        ptr     <= (int'(gnt_idx) == NUM_REQ - 1) ? 2'd0 : gnt_idx + 2'd1;
                        cur_idx <= gnt_idx;
                        paddr   <= sel_addr;
                        pwrite  <= sel_write;
                        pprot   <= sel_prot;
                        pwdata  <= sel_wdata;
                        pstrb   <= sel_write ? sel_strb : 4'd0;
                        psel    <= 4'b0001 << sel_addr[SLV_LSB +: 2];
                        penable <= 1'b0;
                        cnt     <= '0;
                    end
                end
                SETUP: penable <= 1'b1;
                ACCESS: begin
                    if (acc_done || acc_tmo) begin
                        psel      <= 4'd0;
                        penable   <= 1'b0;
                        cnt       <= '0;
                        rsp_valid <= NUM_REQ'(1) << cur_idx;
                        rsp_err   <= acc_tmo ? 1'b1 : pslverr;
                        rsp_rdata <= (acc_done && !pwrite) ? prdata : 32'd0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_sched.sv
// Randomized bench for apb_master_sched: requesters and slave are driven from a
// transaction timeline that predicts grants, bus phases and responses.
module tb_apb_master_sched;

    localparam int NUM_REQ = 3;
    localparam int SLV_LSB = 12;
    localparam int TIMEOUT = 16;
    localparam int RW      = 35;

    logic                  pclk = 1'b0;
    logic                  preset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_write;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [4*NUM_REQ-1:0]  req_strb;
    logic [3*NUM_REQ-1:0]  req_prot;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [3:0]            psel;
    logic                  penable;
    logic [31:0]           paddr;
    logic                  pwrite;
    logic [2:0]            pprot;
    logic [31:0]           pwdata;
    logic [3:0]            pstrb;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;
    logic [1:0]            dbg_state;

    apb_master_sched #(.NUM_REQ(NUM_REQ), .SLV_LSB(SLV_LSB), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    // transaction-level model state
    int          cyc = 0;
    int          ptr_m = 0;
    bit          busy = 1'b0;
    int          t_grant, t_resp, w_cur, g_cur;
    logic [31:0] x_addr, x_wdata, p_rdata, last_rdata;
    logic        x_write, p_err, last_err;
    logic [3:0]  x_strb;
    logic [2:0]  x_prot;
    bit          pend[NUM_REQ];
    bit          force_tmo = 1'b0;
    logic [RW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".psel"}, 64'(psel), 64'd0);
        check({tag, ".penable"}, 64'(penable), 64'd0);
        check({tag, ".req_ready"}, 64'(req_ready), 64'd0);
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, ".rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, ".paddr"}, 64'(paddr), 64'd0);
        check({tag, ".pstrb"}, 64'(pstrb), 64'd0);
        check({tag, ".pwdata"}, 64'(pwdata), 64'd0);
        check({tag, ".pwrite"}, 64'(pwrite), 64'd0);
        check({tag, ".pprot"}, 64'(pprot), 64'd0);
        check({tag, ".state"}, 64'(dbg_state), 64'd0);
    endtask

    task automatic new_fields(input int i);
        req_addr[32*i +: 32]  = $urandom;
        req_wdata[32*i +: 32] = $urandom;
        req_write[i]          = 1'($urandom_range(0, 1));
        req_strb[4*i +: 4]    = 4'($urandom_range(0, 15));
        req_prot[3*i +: 3]    = 3'($urandom_range(0, 7));
    endtask

    // driver: requester fields stay frozen while pending, churn otherwise
    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i]) begin
                new_fields(i);
                if ($urandom_range(0, 99) < 40) pend[i] = 1'b1;
            end else if ($urandom_range(0, 99) < 3) begin
                pend[i] = 1'b0;
            end
            req_valid[i] = pend[i];
        end
        if (busy && w_cur < TIMEOUT && cyc == t_grant + 2 + w_cur) begin
            pready  = 1'b1;
            pslverr = p_err;
            prdata  = p_rdata;
        end else if (busy && cyc >= t_grant + 2 && cyc < t_resp) begin
            pready  = 1'b0;
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end else begin
            pready  = 1'($urandom_range(0, 1));
            pslverr = 1'($urandom_range(0, 1));
            prdata  = $urandom;
        end
    endtask

    // scoreboard: evaluate one cycle of the timeline against the DUT
    task automatic check_cycle();
        logic [RW-1:0] e;
        logic [3:0]    exp_sel;
        int            g;
        int            idx;
        int            wsel;
        if (busy && cyc == t_resp) begin
            busy = 1'b0;
            if (exp_q.size() == 0) begin
                check("rsp_queue_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                last_err   = e[32];
                last_rdata = e[31:0];
                check("rsp_valid", 64'(rsp_valid), 64'(1) << e[34:33]);
            end
        end else begin
            check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
        end
        check("rsp_rdata", 64'(rsp_rdata), 64'(last_rdata));
        check("rsp_err", 64'(rsp_err), 64'(last_err));

        if (busy) begin
            exp_sel = 4'b0001 << x_addr[SLV_LSB +: 2];
            check("psel", 64'(psel), 64'(exp_sel));
            check("penable", 64'(penable), (cyc == t_grant + 1) ? 64'd0 : 64'd1);
            check("paddr", 64'(paddr), 64'(x_addr));
            check("pwrite", 64'(pwrite), 64'(x_write));
            check("pprot", 64'(pprot), 64'(x_prot));
            check("pstrb", 64'(pstrb), x_write ? 64'(x_strb) : 64'd0);
            if (x_write) check("pwdata", 64'(pwdata), 64'(x_wdata));
            check("req_ready_busy", 64'(req_ready), 64'd0);
        end else begin
            check("psel_idle", 64'(psel), 64'd0);
            check("penable_idle", 64'(penable), 64'd0);
            check("state_idle", 64'(dbg_state), 64'd0);
            g = -1;
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = (ptr_m + k) % NUM_REQ;
                if (req_valid[idx]) g = idx;
            end
            check("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
            if (g >= 0) begin
                busy    = 1'b1;
                g_cur   = g;
                t_grant = cyc;
                ptr_m   = (g + 1) % NUM_REQ;
                pend[g] = 1'b0;
                x_addr  = req_addr[32*g +: 32];
                x_wdata = req_wdata[32*g +: 32];
                x_write = req_write[g];
                x_strb  = req_strb[4*g +: 4];
                x_prot  = req_prot[3*g +: 3];
                wsel    = $urandom_range(0, 9);
                if (force_tmo)      w_cur = 40;
                else if (wsel < 5)  w_cur = 0;
                else if (wsel < 8)  w_cur = $urandom_range(1, 4);
                else if (wsel == 8) w_cur = TIMEOUT - 1;
                else                w_cur = $urandom_range(TIMEOUT, TIMEOUT + 4);
                p_err   = ($urandom_range(0, 3) == 0);
                p_rdata = $urandom;
                t_resp  = t_grant + 3 + ((w_cur < TIMEOUT) ? w_cur : TIMEOUT - 1);
                if (w_cur >= TIMEOUT) exp_q.push_back({2'(g), 1'b1, 32'd0});
                else exp_q.push_back({2'(g), p_err, x_write ? 32'd0 : p_rdata});
            end
        end
    endtask

    task automatic do_cycle();
        @(posedge pclk);
        cyc++;
        #1;
        drive();
        @(negedge pclk);
        check_cycle();
    endtask

    task automatic model_reset();
        busy       = 1'b0;
        ptr_m      = 0;
        last_rdata = 32'd0;
        last_err   = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        preset    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        prdata    = 32'd0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check_all_zero("reset");
        preset = 1'b1;

        repeat (600) do_cycle();

        // reset in the middle of a stalled ACCESS
        force_tmo = 1'b1;
        for (int k = 0; k < 200 && !(busy && cyc >= t_grant + 4); k++) do_cycle();
        force_tmo = 1'b0;
        check("reached_access_wait", 64'(penable && busy), 64'd1);
        #2;
        preset    = 1'b0;
        req_valid = '1;
        #1;
        check("rst_async.psel", 64'(psel), 64'd0);
        check("rst_async.penable", 64'(penable), 64'd0);
        check("rst_async.req_ready", 64'(req_ready), 64'd0);
        check("rst_async.rsp_valid", 64'(rsp_valid), 64'd0);
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            new_fields(i);
            pend[i] = 1'b1;
        end
        repeat (3) begin
            @(negedge pclk);
            check_all_zero("in_reset");
        end
        @(posedge pclk);
        #1;
        req_valid = '0;
        preset    = 1'b1;

        repeat (300) do_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
